// File: rtl/window_load_responder.sv
// Vector-load responder: fetches WINDOW consecutive RAM words for each load request and
// returns them as one flattened vector; forwards single-word writes to the RAM while idle.
module window_load_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int WINDOW     = 25,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [WINDOW*DATA_W-1:0] rsp_data,
    input  logic                     rsp_ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd_en,
    output logic                     mem_wr_en,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESP} state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
    logic                            mem_rd_en_q, mem_rd_en_d;
    logic                            mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0]               mem_wdata_q, mem_wdata_d;
    logic [RD_LATENCY-1:0]           vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0][CNT_W-1:0] slot_pipe_q, slot_pipe_d;
    logic [WINDOW*DATA_W-1:0]        rsp_data_q, rsp_data_d;
    logic                            cap_vld;
    logic [CNT_W-1:0]                cap_slot;

    assign cap_vld  = vld_pipe_q[RD_LATENCY-1];
    assign cap_slot = slot_pipe_q[RD_LATENCY-1];

    // Each issued read carries its slot index down a pipe matching the RAM latency,
    // so capture needs no knowledge of when the read was issued.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        slot_pipe_d    = slot_pipe_q;
        vld_pipe_d[0]  = mem_rd_en_q;
        slot_pipe_d[0] = cnt_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            slot_pipe_d[i] = slot_pipe_q[i-1];
        end
        rsp_data_d = rsp_data_q;
        if (cap_vld) begin
            rsp_data_d[cap_slot*DATA_W +: DATA_W] = mem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready  = 1'b1;
                req_ready = !wr_en;
                if (wr_en) begin
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                end else if (req_valid) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = req_addr;
                    cnt_d       = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                // cnt_q is the slot whose read is on the RAM port this cycle
                if (cnt_q == LAST_SLOT) begin
                    state_d = DRAIN;
                end else begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cap_vld && cap_slot == LAST_SLOT) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= '0;
            vld_pipe_q  <= '0;
            slot_pipe_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            vld_pipe_q  <= vld_pipe_d;
            slot_pipe_q <= slot_pipe_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_window_load_responder.sv
// Scoreboard bench for window_load_responder: two instances (read latency 1 and 3) each run
// directed scenarios plus randomized traffic against a RAM model and a shadow-memory reference.
module tb_window_load_responder;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int WIN = 25;

    typedef struct {
        int                 cyc;
        logic [WIN*DW-1:0]  data;
    } rsp_exp_t;

    typedef struct {
        int           cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks   = 0;
    int n_fail     = 0;
    int lanes_done = 0;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 37 + 23100);
    endfunction

    task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane=%0d cyc=%0d actual=%h required=%h", nm, lane, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic                 reset, req_valid, req_ready, rsp_valid, rsp_ready;
        logic                 wr_en, wr_ready, mem_rd_en, mem_wr_en;
        logic [AW-1:0]        req_addr, wr_addr, mem_addr;
        logic [DW-1:0]        wr_data, mem_wdata, mem_rdata;
        logic [WIN*DW-1:0]    rsp_data;

        window_load_responder #(
            .DATA_W(DW), .ADDR_W(AW), .WINDOW(WIN), .RD_LATENCY(LAT)
        ) dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
            .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
            .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        // RAM model; junk on the read port whenever no read is due
        logic [DW-1:0] ram [0:65535];
        logic [DW-1:0] rd_pipe [0:LAT-1];
        assign mem_rdata = rd_pipe[LAT-1];

        initial begin
            for (int a = 0; a < 65536; a++) ram[a] = init_val(a);
            forever begin
                @(posedge clk);
                for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
                rd_pipe[0] <= mem_rd_en ? ram[mem_addr] : DW'($urandom);
                if (mem_wr_en) ram[mem_addr] = mem_wdata;
            end
        end

        logic [DW-1:0] shadow [0:65535];
        rsp_exp_t      rsp_q[$];
        mem_exp_t      rd_q[$];
        mem_exp_t      wr_q[$];

        // Monitor
        initial begin
            logic              pv;
            logic [WIN*DW-1:0] pd;
            rsp_exp_t          e;
            mem_exp_t          m;
            pv = 1'b0;
            pd = '0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    pv = 1'b0;
                    continue;
                end
                if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", g, 1, 0);
                if (mem_rd_en) begin
                    if (rd_q.size() == 0) chk("spurious_rd", g, 1, 0);
                    else begin
                        m = rd_q.pop_front();
                        chk("rd_cycle", g, cyc, m.cyc);
                        chk("rd_addr", g, 32'(mem_addr), 32'(m.addr));
                    end
                end
                if (mem_wr_en) begin
                    if (wr_q.size() == 0) chk("spurious_wr", g, 1, 0);
                    else begin
                        m = wr_q.pop_front();
                        chk("wr_cycle", g, cyc, m.cyc);
                        chk("wr_addr", g, 32'(mem_addr), 32'(m.addr));
                        chk("wr_data", g, 32'(mem_wdata), 32'(m.data));
                    end
                end
                if (rsp_valid) begin
                    chk("busy_wr_ready", g, 32'(wr_ready), 0);
                    chk("busy_req_ready", g, 32'(req_ready), 0);
                    if (!pv) begin
                        if (rsp_q.size() == 0) chk("spurious_rsp", g, 1, 0);
                        else begin
                            e = rsp_q.pop_front();
                            chk("rsp_cycle", g, cyc, e.cyc);
                            for (int k = 0; k < WIN; k++)
                                chk($sformatf("rsp_slot%0d", k), g, 32'(rsp_data[k*DW +: DW]), 32'(e.data[k*DW +: DW]));
                        end
                    end else begin
                        chk("rsp_stable", g, 32'(rsp_data == pd), 1);
                    end
                end
                pv = rsp_valid && !rsp_ready;
                pd = rsp_data;
            end
        end

        task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
            mem_exp_t m;
            wr_en = 1'b1; wr_addr = a; wr_data = d;
            @(negedge clk);
            chk("wr_ready_idle", g, 32'(wr_ready), 1);
            m.cyc = cyc + 1; m.addr = a; m.data = d;
            wr_q.push_back(m);
            shadow[a] = d;
            @(posedge clk); #1;
            wr_en = 1'b0;
        endtask

        // Presents a load; returns acceptance cycle or -1
        task automatic issue_load(input logic [AW-1:0] base, output int t);
            rsp_exp_t e;
            mem_exp_t m;
            logic [AW-1:0] a;
            req_valid = 1'b1; req_addr = base;
            @(negedge clk);
            chk("req_ready_idle", g, 32'(req_ready), 1);
            t = req_ready ? cyc : -1;
            if (t >= 0) begin
                for (int k = 0; k < WIN; k++) begin
                    a = base + AW'(k);
                    m.cyc = t + 1 + k; m.addr = a; m.data = '0;
                    rd_q.push_back(m);
                    e.data[k*DW +: DW] = shadow[a];
                end
                e.cyc = t + 1 + WIN + LAT;
                rsp_q.push_back(e);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
        endtask

        task automatic do_load(input logic [AW-1:0] base, input int hold, input bit junk);
            int t;
            int w;
            rsp_ready = (hold == 0);
            issue_load(base, t);
            if (t < 0) return;
            w = 0;
            forever begin
                @(negedge clk);
                if (rsp_valid || w > 100) break;
                chk("busy_ready", g, {30'd0, req_ready, wr_ready}, 0);
                if (junk) begin
                    wr_en = 1'($urandom); req_valid = 1'($urandom);
                    wr_addr = AW'($urandom); wr_data = DW'($urandom); req_addr = AW'($urandom);
                end
                w++;
            end
            wr_en = 1'b0; req_valid = 1'b0;
            chk("rsp_timeout", g, 32'(rsp_valid), 1);
            if (hold > 0) begin
                repeat (hold) @(posedge clk);
                #1 rsp_ready = 1'b1;
                @(negedge clk);
                chk("valid_until_ready", g, 32'(rsp_valid), 1);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("idle_after_hs_valid", g, 32'(rsp_valid), 0);
            chk("idle_after_hs_ready", g, {30'd0, req_ready, wr_ready}, 3);
            @(posedge clk); #1;
        endtask

        initial begin
            int t;
            for (int a = 0; a < 65536; a++) shadow[a] = init_val(a);
            reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
            wr_en = 1'b0; wr_addr = '0; wr_data = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("rst_rsp_valid", g, 32'(rsp_valid), 0);
            chk("rst_rsp_data_zero", g, 32'(rsp_data == '0), 1);
            chk("rst_mem_strobes", g, {30'd0, mem_rd_en, mem_wr_en}, 0);
            chk("rst_mem_addr", g, 32'(mem_addr), 0);
            chk("rst_mem_wdata", g, 32'(mem_wdata), 0);
            chk("rst_ready", g, {30'd0, req_ready, wr_ready}, 3);
            @(posedge clk); #1;
            reset = 1'b0;

            // write then load
            for (int k = 0; k < WIN; k++) do_write(AW'(16'h0200 + k), DW'(16'h0100 + k));
            do_load(16'h0200, 0, 0);

            // write beats load in the same idle cycle
            wr_en = 1'b1; wr_addr = 16'h0205; wr_data = 16'hBEEF;
            req_valid = 1'b1; req_addr = 16'h0200;
            @(negedge clk);
            chk("prio_req_ready", g, 32'(req_ready), 0);
            chk("prio_wr_ready", g, 32'(wr_ready), 1);
            wr_q.push_back('{cyc: cyc + 1, addr: 16'h0205, data: 16'hBEEF});
            shadow[16'h0205] = 16'hBEEF;
            @(posedge clk); #1;
            wr_en = 1'b0;
            do_load(16'h0200, 0, 0);

            // backpressure
            do_load(16'h0203, 10, 0);

            // address wrap
            for (int k = 0; k < WIN; k++) do_write(AW'(16'hFFF0 + k), DW'($urandom));
            do_load(16'hFFF0, 2, 0);

            // reset mid-fetch
            rsp_ready = 1'b0;
            issue_load(16'h0200, t);
            repeat (9) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            rd_q.delete();
            rsp_q.delete();
            #1 reset = 1'b0;
            @(negedge clk);
            chk("rstmid_rsp_valid", g, 32'(rsp_valid), 0);
            chk("rstmid_rd_en", g, 32'(mem_rd_en), 0);
            chk("rstmid_req_ready", g, 32'(req_ready), 1);
            chk("rstmid_rsp_data", g, 32'(rsp_data == '0), 1);
            repeat (12) @(posedge clk);
            #1;
            do_load(16'h0200, 1, 0);

            // randomized traffic
            for (int it = 0; it < 40; it++) begin
                int nw;
                nw = $urandom_range(0, 4);
                for (int j = 0; j < nw; j++)
                    do_write(AW'(16'h0300 + $urandom_range(0, 63)), DW'($urandom));
                if ($urandom_range(0, 3) == 0)
                    do_load(AW'($urandom), $urandom_range(0, 3), 1);
                else
                    do_load(AW'(16'h02F0 + $urandom_range(0, 80)), $urandom_range(0, 3), 1);
            end
            repeat (4) @(posedge clk);
            chk("rd_q_drained", g, rd_q.size(), 0);
            chk("rsp_q_drained", g, rsp_q.size(), 0);
            chk("wr_q_drained", g, wr_q.size(), 0);
            lanes_done++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && lanes_done < 2; i++) @(posedge clk);
        if (lanes_done < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout lanes_done=%0d required=2", lanes_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_load_responder.md
Name: window_load_responder

Overview:
Memory-side responder for the vector-load interface used by the CNN control blocks, such as the bias repeater and the kernel loaders. On a load request it fetches WINDOW consecutive words from a single-port RAM, one per cycle, and returns them as one flattened vector through a valid/ready handshake. While idle it also forwards single-word write requests to the same RAM. It sits between the CNN control blocks and the feature/weight RAM.

Parameters:
DATA_W, 16, word width.
ADDR_W, 16, RAM address width.
WINDOW, 25, words per vector load.
RD_LATENCY, 1, RAM read latency in cycles (legal values 1..4).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  vector-load request
req_addr  in  ADDR_W  base address of the window
req_ready  out  1  request accepted when high together with req_valid
rsp_valid  out  1  vector valid
rsp_data  out  WINDOW*DATA_W  vector; slot k occupies bits [k*DATA_W +: DATA_W]
rsp_ready  in  1  consumer accepts the vector
wr_en  in  1  single-word write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write accepted when high together with wr_en
mem_addr  out  ADDR_W  RAM address (registered)
mem_rd_en  out  1  RAM read strobe (registered)
mem_wr_en  out  1  RAM write strobe (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid RD_LATENCY cycles after mem_rd_en

Behaviour:
- States: IDLE, FETCH, DRAIN, RESP.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including rsp_data, except req_ready and wr_ready, which follow the IDLE rules below.
  - The fetch counter and the read-valid pipeline are cleared.
- IDLE:
  - wr_ready = 1.
  - req_ready = !wr_en. A write has priority over a load in the same cycle.
- Write path:
  - A write is accepted at the edge of cycle T.
  - In cycle T+1: mem_wr_en = 1, mem_addr = wr_addr, mem_wdata = wr_data, for exactly one cycle.
  - Back-to-back writes are allowed every cycle.
  - mem_wr_en and mem_rd_en are never high together.
- Load accepted at the edge of cycle T:
  - Latch base = req_addr and go to FETCH.
  - req_ready = 0 and wr_ready = 0 in every state except IDLE.
- FETCH:
  - In cycle T+1+k, for k = 0..WINDOW-1: mem_rd_en = 1 and mem_addr = base + k, mod 2^ADDR_W (wraps with no error).
  - After k = WINDOW-1, go to DRAIN.
- Capture:
  - A RD_LATENCY-deep shift register tracks each issued read's valid bit and slot index.
  - Slot k is loaded from mem_rdata at the end of cycle T+1+k+RD_LATENCY.
  - Slots not yet loaded keep their previous values.
- DRAIN:
  - mem_rd_en = 0.
  - Wait until the last slot (k = WINDOW-1) is captured, then go to RESP.
- RESP:
  - rsp_valid = 1 from cycle T+1+WINDOW+RD_LATENCY (T+27 for the defaults).
  - rsp_valid and rsp_data are held stable until rsp_ready = 1.
  - At the handshake edge go to IDLE; rsp_valid = 0 in the next cycle.
- rsp_ready:
  - Ignored outside RESP.
  - If rsp_ready is already high when rsp_valid rises, the vector is valid for exactly one cycle.
- New requests:
  - req_valid is not accepted outside IDLE, so there is no queueing.
  - The earliest next acceptance is the cycle after the response handshake.
- rsp_data:
  - After a handshake rsp_data keeps its last value, but it is meaningful only while rsp_valid = 1.
- Reset mid-operation:
  - Return to IDLE immediately.
  - The read pipeline is flushed, and in-flight mem_rdata is discarded.
  - rsp_valid = 0 and rsp_data = 0.
  - No further mem strobes are issued until a new request is accepted.
- WINDOW = 1:
  - FETCH lasts one cycle; the behaviour is otherwise identical.

Test Plan:
- Write then load: write 0x0100+k to addresses 0x0200..0x0218 (25 writes), then load base 0x0200 at cycle T. Required: mem_rd_en high in T+1..T+25; rsp_valid at T+27 with slot k = 0x0100+k.
- Priority: req_valid and wr_en high in the same IDLE cycle. Required: the write is accepted (mem_wr_en next cycle), req_ready = 0 that cycle, and the load is accepted one cycle later.
- Backpressure: rsp_ready is held low for 10 cycles after rsp_valid rises. Required: rsp_valid and rsp_data stay stable and wr_ready = 0 throughout; IDLE is entered the cycle after rsp_ready is raised.
- Address wrap: load base 0xFFF0. Required: mem_addr runs 0xFFF0..0xFFFF, then 0x0000..0x0008; the slot order matches that sequence.
- Reset mid-fetch: assert reset at fetch cycle T+10. Required: the next cycle shows rsp_valid = 0, mem_rd_en = 0 and req_ready = 1; no stale rsp_valid afterwards; a fresh load returns correct data.
- Latency sweep: rerun the first scenario with RD_LATENCY = 3. Required: rsp_valid at T+29 with the same data.
